parity_frame_receiver: RTL and testbench
========================================

// Module: parity_frame_receiver
// PURPOSE
//  Serial receive end of the team's 16-bit parity-protected link: the checking counterpart of the 16-bit parity generator.
//  Deserialises one frame (start, 16 data LSB-first, parity, stop) from an async line.
//  Recomputes parity in odd or even mode and flags parity and framing errors.
//  Hands each word to the consumer over a valid/ready handshake.
// PARAMETERS
//  CLKS_PER_BIT   16   clk cycles per serial bit; even, >= 4
//  DATA_W         16   data bits per frame; fixed, from package
// PORTS
//  clk         in   1       single system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  rx_serial   in   1       async serial line, idle high
//  odd_mode    in   1       1 = odd parity, 0 = even; captured at start-bit confirm
//  data_out    out  16      received word
//  data_valid  out  1       data_out/parity_err/frame_err valid
//  data_ready  in   1       consumer accepts when data_valid & data_ready
//  parity_err  out  1       parity mismatch for the presented word
//  frame_err   out  1       stop bit sampled 0 for the presented word
//  overrun     out  1       1-cycle pulse: a frame completed while data_valid was still high
//  busy        out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM = IDLE, counters 0, synchroniser flops = 1.
//  - rx_serial passes a 2-FF synchroniser; all decisions use the synchronised value rxs.
//  - IDLE: on rxs == 0, go to START and clear the baud counter.
//  - START: at count CLKS_PER_BIT/2-1 resample.
//    - rxs == 1: glitch, back to IDLE, no outputs change.
//    - otherwise latch odd_mode, go to DATA.
//  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift in LSB first, XOR each bit into a running parity.
//    After DATA_W bits, go to PARITY.
//  - PARITY: sample the bit and XOR it in.
//    - Even mode: error if the total XOR is 1.
//    - Odd mode: error if the total XOR is 0.
//  - STOP: sample; stop = 0 sets frame_err.
//    - Word completes on this sample: one cycle later data_out/flags load and data_valid = 1, unless overrun applies.
//    - Next state: IDLE if stop = 1, else BREAK.
//  - BREAK: wait until rxs == 1, then IDLE. A low line is never taken as a new start.
//  - Handshake:
//    - data_valid holds, with data_out/flags stable, until the cycle data_valid & data_ready.
//    - data_valid drops the next cycle.
//    - Completion and accept in the same cycle: the new word loads and data_valid stays 1.
//  - Overrun: completion while data_valid = 1 and data_ready = 0.
//    - The new word is dropped; the held word and its flags are unchanged.
//    - overrun = 1 for exactly one cycle.
//  - Latency: falling line edge to data_valid ~ 2 + (DATA_W+2.5)*CLKS_PER_BIT + 1 cycles.
//  - Reset mid-frame: immediate return to reset values; the partial word is discarded.
//  - The baud counter wraps at CLKS_PER_BIT-1; the bit counter is sized clog2(DATA_W+1).
// STRUCTURE
//  - parity_pkg holds:
//    - state enum {IDLE, START, DATA, PARITY, STOP, BREAK};
//    - DATA_W = 16;
//    - PAR_EVEN = 1'b0, PAR_ODD = 1'b1.
//  - One sub-module, rx_sync_2ff: a 2-flop synchroniser, reset to 1.
//  - The FSM, baud/bit counters, shift register and output register stay in this module.
// TESTING (CLKS_PER_BIT=16, line driven bit-accurately)
//  1 Even, data 16'hA5A5, parity bit 0, stop 1, data_ready=1 -> data_out=A5A5, parity_err=0, frame_err=0, one data_valid.
//  2 Even, 16'hA5A5, parity bit 1 -> data_valid with parity_err=1.
//    Odd, 16'h0001, parity bit 0 -> parity_err=0.
//  3 Stop bit 0, line held low 40 clks then high -> frame_err=1, busy through BREAK, no second frame decoded.
//  4 Line low for 4 clks only -> busy returns to 0 after START, no data_valid.
//  5 data_ready=0, frames 16'h1234 then 16'hBEEF.
//    -> overrun pulses 1 cycle, data_out stays 1234.
//    -> after data_ready=1, data_valid drops.
//  6 rst asserted during DATA bit 7 -> outputs 0 immediately.
//    A clean frame 16'h00FF (even, parity 0) afterwards is received correctly.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the 16-bit parity-protected serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parity_pkg;

  localparam int DATA_W = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, resetting to the idle-high level.
// Latency: 2 clk cycles.
// Backpressure: none; free-running.
module rx_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Resolve metastability on the first flop; the second presents a clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_frame_receiver.sv
// Receives start + DATA_W bits LSB-first + parity + stop, checks parity/framing, presents word.
// Latency: ~2 + (DATA_W+2.5)*CLKS_PER_BIT + 1 clk from falling start edge to data_valid.
// Backpressure: valid/ready; a word completing while one is still held is dropped and overrun pulses.
module parity_frame_receiver
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  input  logic              odd_mode,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  rx_state_t         state, state_nxt;
  logic              rxs;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_acc;
  logic              odd_q;
  logic              bit_tick;
  logic              start_ok;
  logic              data_smp;
  logic              par_smp;
  logic              stop_smp;

  rx_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs)
  );

  assign bit_tick = (baud_cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle sample strobes.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    data_smp  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    case (state)
      IDLE:   if (!rxs) state_nxt = START;
      START: begin
        if (baud_cnt == CNT_HALF) begin
          if (rxs) begin
            state_nxt = IDLE;
          end else begin
            start_ok  = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          data_smp = 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_smp   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          stop_smp  = 1'b1;
          state_nxt = rxs ? IDLE : BREAK;
        end
      end
      BREAK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter: phase-aligns to the start-bit centre, then ticks once per bit at mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else begin
      case (state)
        START:               baud_cnt <= start_ok ? '0 : baud_cnt + 1'b1;
        DATA, PARITY, STOP:  baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
        default:             baud_cnt <= '0;
      endcase
    end
  end

  // Shift register, bit counter, running parity and parity mode captured per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_acc <= 1'b0;
      odd_q   <= PAR_EVEN;
    end else if (start_ok) begin
      bit_cnt <= '0;
      par_acc <= 1'b0;
      odd_q   <= odd_mode;
    end else if (data_smp) begin
      bit_cnt <= bit_cnt + 1'b1;
      shift   <= {rxs, shift[DATA_W-1:1]};
      par_acc <= par_acc ^ rxs;
    end else if (par_smp) begin
      par_acc <= par_acc ^ rxs;
    end
  end

  // Output holding register with handshake; a completion onto an unaccepted word is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stop_smp) begin
        if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end else begin
          data_out   <= shift;
          parity_err <= par_acc ^ (odd_q == PAR_ODD);
          frame_err  <= ~rxs;
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_receiver.sv
module tb_parity_frame_receiver;

  localparam int CPB = 16;

  typedef struct packed {
    logic [15:0] d;
    logic        pe;
    logic        fe;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic        odd_mode;
  logic        data_ready;
  logic [15:0] data_out;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int    vectors     = 0;
  int    miscompares = 0;
  int    ovr_cycles  = 0;
  word_t got_q[$];

  always #5 clk = ~clk;

  parity_frame_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .odd_mode   (odd_mode),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Collect every accepted word and count overrun-high cycles, sampled mid-cycle.
  always @(negedge clk) begin
    word_t w;
    if (data_valid && data_ready) begin
      w = {data_out, parity_err, frame_err};
      got_q.push_back(w);
    end
    if (overrun) ovr_cycles++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic b);
    rx_serial = b;
    clks(CPB);
  endtask

  task automatic send_frame(input logic [15:0] d, input logic pb, input logic sb);
    line_bit(1'b0);
    for (int i = 0; i < 16; i++) line_bit(d[i]);
    line_bit(pb);
    line_bit(sb);
  endtask

  // Reference: parity error when the count of ones over data+parity bit has the wrong oddness.
  function automatic word_t model(input logic [15:0] d, input logic pb, input logic odd, input logic sb);
    int    ones;
    word_t w;
    ones = $countones(d) + int'(pb);
    w.d  = d;
    w.pe = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    w.fe = (sb == 1'b0);
    return w;
  endfunction

  task automatic expect_word(input string tag, input word_t exp);
    word_t w;
    chk({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      chk({tag, "_data"}, w.d, exp.d);
      chk({tag, "_perr"}, w.pe, exp.pe);
      chk({tag, "_ferr"}, w.fe, exp.fe);
    end
    got_q.delete();
  endtask

  initial begin
    logic [15:0] d;
    logic        pb, sb, o;
    int          ovr0;

    rst        = 1'b1;
    rx_serial  = 1'b1;
    odd_mode   = 1'b0;
    data_ready = 1'b1;
    clks(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data",  data_out,   0);
    chk("rst_perr",  parity_err, 0);
    chk("rst_ferr",  frame_err,  0);
    chk("rst_ovr",   overrun,    0);
    chk("rst_busy",  busy,       0);
    rst = 1'b0;
    clks(4);
    chk("idle_busy", busy, 0);

    // Clean even frame.
    send_frame(16'hA5A5, 1'b0, 1'b1);
    clks(4);
    expect_word("s1", model(16'hA5A5, 1'b0, 1'b0, 1'b1));

    // Bad even parity, then good odd parity.
    send_frame(16'hA5A5, 1'b1, 1'b1);
    clks(4);
    expect_word("s2_even_bad", model(16'hA5A5, 1'b1, 1'b0, 1'b1));
    odd_mode = 1'b1;
    send_frame(16'h0001, 1'b0, 1'b1);
    clks(4);
    expect_word("s2_odd_ok", model(16'h0001, 1'b0, 1'b1, 1'b1));
    odd_mode = 1'b0;

    // Framing error followed by a held-low line.
    send_frame(16'h3C3C, 1'b0, 1'b0);
    clks(20);
    chk("s3_busy_break", busy, 1);
    clks(20);
    rx_serial = 1'b1;
    clks(6);
    chk("s3_busy_after", busy, 0);
    clks(40);
    expect_word("s3", model(16'h3C3C, 1'b0, 1'b0, 1'b0));

    // Short glitch rejected in START.
    rx_serial = 1'b0;
    clks(4);
    rx_serial = 1'b1;
    chk("s4_busy_start", busy, 1);
    clks(20);
    chk("s4_busy_idle", busy, 0);
    chk("s4_no_word", got_q.size(), 0);
    chk("s4_no_valid", data_valid, 0);

    // Overrun: consumer stalled across two frames.
    data_ready = 1'b0;
    ovr0 = ovr_cycles;
    send_frame(16'h1234, ^16'h1234, 1'b1);
    clks(4);
    chk("s5_valid1", data_valid, 1);
    chk("s5_data1",  data_out, 16'h1234);
    send_frame(16'hBEEF, ^16'hBEEF, 1'b1);
    clks(4);
    chk("s5_ovr_cycles", ovr_cycles - ovr0, 1);
    chk("s5_hold_data",  data_out, 16'h1234);
    chk("s5_hold_valid", data_valid, 1);
    chk("s5_hold_perr",  parity_err, 0);
    data_ready = 1'b1;
    clks(1);
    chk("s5_valid_drop", data_valid, 0);
    expect_word("s5", model(16'h1234, ^16'h1234, 1'b0, 1'b1));

    // Reset in the middle of data bit 7, then a clean frame.
    d = 16'h5A5A;
    line_bit(1'b0);
    for (int i = 0; i < 7; i++) line_bit(d[i]);
    rx_serial = d[7];
    clks(8);
    chk("s6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("s6_rst_busy",  busy,       0);
    chk("s6_rst_valid", data_valid, 0);
    chk("s6_rst_data",  data_out,   0);
    chk("s6_rst_perr",  parity_err, 0);
    rx_serial = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(4);
    got_q.delete();
    send_frame(16'h00FF, 1'b0, 1'b1);
    clks(4);
    expect_word("s6", model(16'h00FF, 1'b0, 1'b0, 1'b1));

    // Randomized frames against the reference model.
    for (int n = 0; n < 10; n++) begin
      d  = 16'($urandom);
      pb = 1'($urandom);
      o  = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      odd_mode = o;
      send_frame(d, pb, sb);
      if (!sb) begin
        clks(8);
        rx_serial = 1'b1;
      end
      clks(6);
      expect_word($sformatf("rnd%0d", n), model(d, pb, o, sb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
